// File: rtl/gsm_sw_pkg.sv
// Shared types for the switch output path: transfer FSM encoding and
// default field widths used by out_xfer_ctrl and its helpers.
package gsm_sw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } xfer_state_t;

    localparam int LEN_W_DEF = 8;
    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/out_xfer_ctrl_pri_enc.sv
// Lowest-set-bit priority encoder with any/multi-hot flags, used to pick
// the winning input from the upstream grant vector.
module pri_enc #(
    parameter int N     = 4,
    parameter int LOG_N = 2
) (
    input  logic [N-1:0]     req,
    output logic [LOG_N-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = LOG_N'(i);
            end
        end
    end

    assign any   = |req;
    assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/out_xfer_ctrl.sv
// Output transfer controller: latches the granted input, streams its packet
// word by word to the output port, then idles one cycle so rr_sch can advance.
module out_xfer_ctrl
    import gsm_sw_pkg::*;
#(
    parameter int NUM_PORT     = 4,
    parameter int LOG_NUM_PORT = 2,
    parameter int DWIDTH       = 32,
    parameter int LEN_W        = LEN_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [NUM_PORT-1:0]        grant,
    output logic                       stall,
    input  logic [NUM_PORT-1:0]        in_valid,
    output logic [NUM_PORT-1:0]        in_ready,
    input  logic [NUM_PORT*DWIDTH-1:0] in_data,
    input  logic [NUM_PORT*LEN_W-1:0]  in_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DWIDTH-1:0]          out_data,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [LOG_NUM_PORT-1:0]    sel_idx,
    output logic                       err_multi,
    output logic [PKT_CNT_W-1:0]       pkt_cnt,
    output xfer_state_t                dbg_state
);

    // Handshake: a word moves on any cycle in XFER where in_valid[sel_idx]
    // and out_ready are both high; in_ready[sel_idx] mirrors out_ready so the
    // upstream FIFO pops exactly when the output accepts.

    xfer_state_t              state_q;
    xfer_state_t              state_d;
    logic [LEN_W-1:0]         rem_q;
    logic [LOG_NUM_PORT-1:0]  sel_q;
    logic                     sop_q;
    logic                     err_q;
    logic [PKT_CNT_W-1:0]     pkt_cnt_q;
    logic [PKT_CNT_W-1:0]     pkt_cnt_nxt;

    logic [LOG_NUM_PORT-1:0]  enc_idx;
    logic                     enc_any;
    logic                     enc_multi;

    logic [DWIDTH-1:0]        data_arr [NUM_PORT];
    logic [LEN_W-1:0]         len_arr  [NUM_PORT];
    logic [LEN_W-1:0]         cap_len;
    logic [LEN_W-1:0]         eff_len;
    logic                     capture;
    logic                     sel_valid;
    logic                     xfer_fire;
    logic                     last_word;

    pri_enc #(
        .N     (NUM_PORT),
        .LOG_N (LOG_NUM_PORT)
    ) u_pri_enc (
        .req   (grant),
        .idx   (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    for (genvar k = 0; k < NUM_PORT; k++) begin : g_unflatten
        assign data_arr[k] = in_data[k*DWIDTH +: DWIDTH];
        assign len_arr[k]  = in_len[k*LEN_W +: LEN_W];
    end

    // A zero length still carries the head word, so it counts as one.
    assign cap_len   = len_arr[enc_idx];
    assign eff_len   = (cap_len == '0) ? LEN_W'(1) : cap_len;
    assign capture   = (state_q == ST_IDLE) && enc_any;
    assign sel_valid = in_valid[sel_q];
    assign xfer_fire = (state_q == ST_XFER) && sel_valid && out_ready;
    assign last_word = (rem_q == LEN_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enc_any) state_d = ST_XFER;
            ST_XFER: if (xfer_fire && last_word) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet context: captured once in IDLE, consumed during XFER.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            rem_q <= '0;
            sel_q <= '0;
            sop_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= capture && enc_multi;
            if (capture) begin
                sel_q <= enc_idx;
                rem_q <= eff_len;
                sop_q <= 1'b1;
            end else if (xfer_fire) begin
                rem_q <= rem_q - LEN_W'(1);
                sop_q <= 1'b0;
            end
        end
    end

    // A clr in the same cycle as the final word aborts it, so no count.
    assign pkt_cnt_nxt = (xfer_fire && last_word && !clr) ? pkt_cnt_q + PKT_CNT_W'(1)
                                                          : pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_nxt;
        end
    end

    // Output logic: everything is quiet outside XFER.
    always_comb begin
        in_ready  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        if (state_q == ST_XFER) begin
            in_ready[sel_q] = out_ready;
            out_valid       = sel_valid;
            out_data        = data_arr[sel_q];
            out_sop         = sop_q;
            out_eop         = last_word;
        end
    end

    assign stall     = (state_q == ST_XFER);
    assign sel_idx   = sel_q;
    assign err_multi = err_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_out_xfer_ctrl.sv
// Directed bench for out_xfer_ctrl: a table of packets plus hand sequences
// for output back-pressure, input gaps, soft clear and counter wrap.
module tb_out_xfer_ctrl;
    import gsm_sw_pkg::*;

    localparam int NUM_PORT     = 4;
    localparam int LOG_NUM_PORT = 2;
    localparam int DWIDTH       = 32;
    localparam int LEN_W        = 8;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       clr;
    logic [NUM_PORT-1:0]        grant;
    logic                       stall;
    logic [NUM_PORT-1:0]        in_valid;
    logic [NUM_PORT-1:0]        in_ready;
    logic [NUM_PORT*DWIDTH-1:0] in_data;
    logic [NUM_PORT*LEN_W-1:0]  in_len;
    logic                       out_valid;
    logic                       out_ready;
    logic [DWIDTH-1:0]          out_data;
    logic                       out_sop;
    logic                       out_eop;
    logic [LOG_NUM_PORT-1:0]    sel_idx;
    logic                       err_multi;
    logic [15:0]                pkt_cnt;
    xfer_state_t                dbg_state;

    out_xfer_ctrl #(
        .NUM_PORT     (NUM_PORT),
        .LOG_NUM_PORT (LOG_NUM_PORT),
        .DWIDTH       (DWIDTH),
        .LEN_W        (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .grant     (grant),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .sel_idx   (sel_idx),
        .err_multi (err_multi),
        .pkt_cnt   (pkt_cnt),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Scoreboard state
    logic [DWIDTH-1:0] exp_q[$];
    int                checks   = 0;
    int                failures = 0;
    logic [15:0]       exp_pkt;
    int                exp_cnt [NUM_PORT];
    int                src_cnt [NUM_PORT];

    function automatic logic [DWIDTH-1:0] mk_word(input int k, input int n);
        logic [7:0] kb;
        kb = 8'hD0 + 8'(k);
        return {kb, 8'h00, n[15:0]};
    endfunction

    // Upstream head-of-line model: each port pops its next word on a handshake.
    always @(posedge clk) begin
        for (int k = 0; k < NUM_PORT; k++) begin
            if (!rst_n) begin
                src_cnt[k] <= 0;
            end else if (in_valid[k] && in_ready[k]) begin
                src_cnt[k] <= src_cnt[k] + 1;
            end
        end
    end

    always_comb begin
        in_data = '0;
        for (int k = 0; k < NUM_PORT; k++) begin
            in_data[k*DWIDTH +: DWIDTH] = mk_word(k, src_cnt[k]);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: the selected port gets the test length, the others a decoy of 7.
    task automatic set_len(input int sel, input int len);
        for (int k = 0; k < NUM_PORT; k++) begin
            in_len[k*LEN_W +: LEN_W] = (k == sel) ? 8'(len) : 8'd7;
        end
    endtask

    // Runs one packet from an IDLE negedge; returns at a negedge in IDLE.
    task automatic run_pkt(input logic [3:0] g, input int len, input int exp_sel,
                           input int exp_words, input bit exp_err,
                           input logic [7:0] rdy_pat, input logic [7:0] vld_pat,
                           input int abort_after);
        int          done_words;
        int          c;
        logic [3:0]  junk;
        logic [3:0]  exp_rdy;
        logic [1:0]  sel2;
        bit          v;
        bit          r;
        sel2 = exp_sel[1:0];
        set_len(exp_sel, len);
        in_valid  = '1;
        out_ready = 1'b1;
        grant     = g;
        #1;
        check("idle_stall", 64'(stall), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(0));
        check("idle_out_valid", 64'(out_valid), 64'(0));
        for (int w = 0; w < exp_words; w++) exp_q.push_back(mk_word(exp_sel, exp_cnt[exp_sel] + w));
        @(negedge clk);
        junk  = (~g != 4'b0) ? ~g : 4'b0001;
        grant = junk;
        #1;
        check("cap_stall", 64'(stall), 64'(1));
        check("cap_sel_idx", 64'(sel_idx), 64'(sel2));
        check("cap_err_multi", 64'(err_multi), 64'(exp_err));
        done_words = 0;
        c = 0;
        while (done_words < exp_words && c < 40) begin
            if (abort_after > 0 && done_words == abort_after) break;
            v = (c < 8) ? vld_pat[c] : 1'b1;
            r = (c < 8) ? rdy_pat[c] : 1'b1;
            in_valid       = 4'hF;
            in_valid[sel2] = v;
            out_ready      = r;
            #1;
            exp_rdy = r ? (4'b0001 << exp_sel) : 4'b0000;
            check("xfer_stall", 64'(stall), 64'(1));
            check("xfer_in_ready", 64'(in_ready), 64'(exp_rdy));
            check("xfer_out_valid", 64'(out_valid), 64'(v));
            if (exp_q.size() > 0) check("xfer_out_data", 64'(out_data), 64'(exp_q[0]));
            check("xfer_sop", 64'(out_sop), 64'(done_words == 0));
            check("xfer_eop", 64'(out_eop), 64'(done_words == exp_words - 1));
            if (c > 0) check("err_one_cycle", 64'(err_multi), 64'(0));
            if (v && r) begin
                void'(exp_q.pop_front());
                done_words++;
            end
            c++;
            @(negedge clk);
        end
        exp_cnt[exp_sel] += done_words;
        if (abort_after > 0 && done_words == abort_after) begin
            out_ready = 1'b0;
            clr       = 1'b1;
            @(negedge clk);
            clr   = 1'b0;
            grant = '0;
            #1;
            check("clr_state", 64'(dbg_state), 64'(ST_IDLE));
            check("clr_stall", 64'(stall), 64'(0));
            check("clr_in_ready", 64'(in_ready), 64'(0));
            check("clr_out_valid", 64'(out_valid), 64'(0));
            check("clr_sel_idx", 64'(sel_idx), 64'(0));
            check("clr_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
            exp_q.delete();
            return;
        end
        check("word_count", 64'(done_words), 64'(exp_words));
        if (done_words == exp_words) exp_pkt = exp_pkt + 16'd1;
        #1;
        check("done_state", 64'(dbg_state), 64'(ST_DONE));
        check("done_stall", 64'(stall), 64'(0));
        check("done_out_valid", 64'(out_valid), 64'(0));
        check("done_in_ready", 64'(in_ready), 64'(0));
        check("done_sel_idx", 64'(sel_idx), 64'(sel2));
        check("done_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        @(negedge clk);
        grant = '0;
        #1;
        check("post_state", 64'(dbg_state), 64'(ST_IDLE));
        check("post_sel_idx", 64'(sel_idx), 64'(sel2));
        exp_q.delete();
    endtask

    typedef struct {
        logic [3:0] grant;
        int         len;
        int         exp_sel;
        int         exp_words;
        bit         exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{grant: 4'b0100, len: 3, exp_sel: 2, exp_words: 3, exp_err: 1'b0};
        vecs[1] = '{grant: 4'b1010, len: 2, exp_sel: 1, exp_words: 2, exp_err: 1'b1};
        vecs[2] = '{grant: 4'b0001, len: 0, exp_sel: 0, exp_words: 1, exp_err: 1'b0};
        vecs[3] = '{grant: 4'b1000, len: 1, exp_sel: 3, exp_words: 1, exp_err: 1'b0};
        vecs[4] = '{grant: 4'b1111, len: 5, exp_sel: 0, exp_words: 5, exp_err: 1'b1};
        vecs[5] = '{grant: 4'b0110, len: 0, exp_sel: 1, exp_words: 1, exp_err: 1'b1};

        rst_n     = 1'b0;
        clr       = 1'b0;
        grant     = 4'b0100;
        in_valid  = '1;
        out_ready = 1'b1;
        in_len    = '0;
        exp_pkt   = 16'd0;
        for (int k = 0; k < NUM_PORT; k++) exp_cnt[k] = 0;

        // Outputs must stay quiet while reset is held, even with a live grant.
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_sop_eop", 64'({out_sop, out_eop}), 64'(0));
        check("rst_sel_idx", 64'(sel_idx), 64'(0));
        check("rst_err_multi", 64'(err_multi), 64'(0));
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;
        grant = '0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_pkt(vecs[i].grant, vecs[i].len, vecs[i].exp_sel, vecs[i].exp_words,
                    vecs[i].exp_err, 8'hFF, 8'hFF, 0);
        end

        // Output back-pressure 1,0,0,1 on a 4-word packet.
        run_pkt(4'b0010, 4, 1, 4, 1'b0, 8'b1111_1001, 8'hFF, 0);
        // Input valid gap on the selected port.
        run_pkt(4'b1000, 3, 3, 3, 1'b0, 8'hFF, 8'b1111_1101, 0);
        // Soft clear after 2 of 5 words, then a fresh grant is taken.
        run_pkt(4'b0010, 5, 1, 5, 1'b0, 8'hFF, 8'hFF, 2);
        run_pkt(4'b0100, 1, 2, 1, 1'b0, 8'hFF, 8'hFF, 0);

        // Preload the counter to its maximum, then one more packet wraps it.
        force dut.pkt_cnt_nxt = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_cnt_nxt;
        exp_pkt = 16'hFFFF;
        #1;
        check("preload_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
        run_pkt(4'b1000, 1, 3, 1, 1'b0, 8'hFF, 8'hFF, 0);
        check("wrap_pkt_cnt", 64'(pkt_cnt), 64'(16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
